uart_inst_rx: RTL and testbench
===============================

# uart_inst_rx

UART receiver that takes the serial line driven into the board (`RsRx`), recovers 8N1 frames (8E1 when parity is compiled in) and presents each received byte as an 8-bit calculator instruction with a one-cycle valid strobe. It sits between the `RsRx` pin and the instruction-issue path, alongside the switch/button entry path. It is the receive-side counterpart of the board's existing UART transmitter on `RsTx`. Defaults match the 100 MHz board clock and the 1 Mbaud link used in simulation.

## Interface
- `CLKS_PER_BIT`, default 100: clock cycles per bit (100 MHz / 1 Mbaud); must be even and ≥ 8.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `rx`  in  1  asynchronous serial input (`RsRx`); idles high.
- `inst_wd`  out  8  last good received byte; reset value 0x00.
- `inst_vld`  out  1  one-cycle strobe; `inst_wd` is valid in the same cycle; reset value 0.
- `frm_err`  out  1  one-cycle strobe on a bad stop bit; reset value 0.
- `par_err`  out  1  one-cycle strobe on a parity mismatch; reset value 0; tied to 0 without the macro.
- `busy`  out  1  high whenever the FSM is not in IDLE; reset value 0.

## Operation
- `rx` passes through a 2-flop synchronizer; the synchronizer resets to 1. All decisions use the synchronized value `rx_s`.
- FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP, WAIT_HI.
- IDLE: when `rx_s` is 0, clear the bit counter and go to START.
- START: count `CLKS_PER_BIT/2` cycles, then sample at mid-bit.
  - `rx_s` = 0: go to DATA.
  - `rx_s` = 1: glitch; return to IDLE with no strobe.
- DATA: sample every `CLKS_PER_BIT` cycles. Shift LSB first into the shift register. After 8 samples, go to PARITY (if present) or STOP.
- PARITY: sample one bit and check for even parity over data + parity bit.
- STOP: sample one bit.
  - Sample = 1, no parity error: load `inst_wd` and pulse `inst_vld`; go to IDLE.
  - Sample = 1, parity error: pulse `par_err`; `inst_wd` is unchanged; go to IDLE.
  - Sample = 0: pulse `frm_err`; `inst_wd` is unchanged; go to WAIT_HI. A parity error in the same frame is superseded; only `frm_err` pulses.
- WAIT_HI: stay until `rx_s` is 1, then go to IDLE. This stops a break condition from being read as back-to-back frames.
- At most one of `inst_vld`, `frm_err`, `par_err` is high in any cycle.
- Baud counter width is `$clog2(CLKS_PER_BIT)`. It reloads to 0 on every sample. No drift accumulates within a frame.

## Timing
- Cycle 0 is the first edge that registers `rx` = 0 into synchronizer stage 1.
- Sample points, measured from cycle 0:
  - start: 2 + `CLKS_PER_BIT/2`
  - data bit k: 2 + `CLKS_PER_BIT/2` + (k+1)·`CLKS_PER_BIT`
  - stop: 2 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` (10· with parity)
- The strobe is registered and goes high one cycle after the stop sample. With defaults that is cycle 953 (1053 with parity).
- The FSM returns to IDLE in the same cycle the strobe is high. A new start bit arriving half a bit after the stop-bit midpoint is accepted; continuous back-to-back frames have no gap requirement.
- `busy` rises the cycle after IDLE sees `rx_s` = 0. It falls in the strobe cycle.
- Reset mid-frame: all outputs return to reset values on the next edge. The partial frame is discarded with no strobe. If the line is still low after reset, that is treated as a new start bit; a bad frame may follow and is reported by `frm_err`.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frame is 8E1 and the PARITY state exists.
  - `par_err` is driven as described above.
- `UART_RX_PARITY_EN` undefined:
  - Frame is 8N1 and the PARITY state is not compiled.
  - `par_err` is a constant 0.

## Structure
- Package `uart_pkg` holds:
  - the FSM state encoding
  - `UART_DEF_CLKS_PER_BIT` = 100
  - the frame length constants (`UART_DATA_BITS` = 8)
- The transmitter reuses this package.
- One sub-module, `uart_sync2`: a 2-flop synchronizer with a reset-to-1 parameter, also reusable for button inputs.

## Test plan
- Reset, then send 0x04 (PUSH r0,4) at 1 Mbaud -> `inst_vld` one cycle at cycle 953 ±1, `inst_wd` = 0x04, `busy` low afterwards.
- Send 0x91 then 0x6E with no idle gap -> two `inst_vld` strobes exactly 1000 cycles apart with 0x91 then 0x6E; no error strobes.
- Drive a 30-cycle low glitch on an idle line -> no strobe; `busy` returns low after the start sample; `inst_wd` unchanged.
- Send 0xA5 with the stop bit forced to 0, then hold the line low for 3 bit times, then send 0x3C -> one `frm_err`, no `inst_vld` for 0xA5, FSM stays in WAIT_HI while low, 0x3C is then received correctly.
- With `UART_RX_PARITY_EN`: send 0x07 with wrong parity -> `par_err` one cycle, `inst_wd` keeps its previous value. Send 0x07 with correct parity (1) -> `inst_vld`, `inst_wd` = 0x07.
- Assert `rst_n` = 0 for 1 cycle at data bit 4 of 0xFF -> all outputs at reset values next cycle. No strobe for that frame (a trailing `frm_err` is allowed). The next clean frame 0x55 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default timing and frame length.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned UART_DEF_CLKS_PER_BIT = 100;
  localparam int unsigned UART_DATA_BITS        = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_WAIT_HI
  } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer with a configurable reset value (1 for idle-high lines).
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic ff1;
  logic ff2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ff1 <= RST_VAL;
      ff2 <= RST_VAL;
    end else begin
      ff1 <= d;
      ff2 <= ff1;
    end
  end

  assign q = ff2;

endmodule

// File: rtl/uart_inst_rx.sv
// UART receiver delivering each byte as a calculator instruction with a valid strobe.
// Define UART_RX_PARITY_EN for 8E1 frames with par_err; otherwise 8N1 and par_err = 0.
module uart_inst_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] inst_wd,
  output logic       inst_vld,
  output logic       frm_err,
  output logic       par_err,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(UART_DATA_BITS - 1);

  logic rx_s;

  uart_state_e               state, state_nxt;
  logic [CNT_W-1:0]          baud_cnt, baud_nxt;
  logic [BIT_W-1:0]          bit_cnt, bit_nxt;
  logic [UART_DATA_BITS-1:0] shreg, sh_nxt;
  logic [7:0]                wd_nxt;
  logic                      vld_nxt, ferr_nxt;
  logic                      tick_half, tick_full;
`ifdef UART_RX_PARITY_EN
  logic                      par_bad, par_bad_nxt, perr_nxt;
`endif

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  assign tick_half = (baud_cnt == HALF_M1);
  assign tick_full = (baud_cnt == FULL_M1);

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    sh_nxt    = shreg;
    wd_nxt    = inst_wd;
    vld_nxt   = 1'b0;
    ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_nxt = par_bad;
    perr_nxt    = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        baud_nxt = '0;
        if (!rx_s) begin
          bit_nxt   = '0;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (tick_half) begin
          baud_nxt  = '0;
          state_nxt = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (tick_full) begin
          baud_nxt = '0;
          sh_nxt   = {rx_s, shreg[UART_DATA_BITS-1:1]};
          bit_nxt  = bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = ST_PARITY;
`else
            state_nxt = ST_STOP;
`endif
          end
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick_full) begin
          baud_nxt    = '0;
          par_bad_nxt = ^{shreg, rx_s};
          state_nxt   = ST_STOP;
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (tick_full) begin
          baud_nxt = '0;
          // A bad stop bit takes priority over any parity error in the frame.
          if (!rx_s) begin
            ferr_nxt  = 1'b1;
            state_nxt = ST_WAIT_HI;
          end
`ifdef UART_RX_PARITY_EN
          else if (par_bad) begin
            perr_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end
`endif
          else begin
            wd_nxt    = shreg;
            vld_nxt   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      ST_WAIT_HI: begin
        baud_nxt = '0;
        if (rx_s) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      inst_wd  <= '0;
      inst_vld <= 1'b0;
      frm_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad  <= 1'b0;
      par_err  <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shreg    <= sh_nxt;
      inst_wd  <= wd_nxt;
      inst_vld <= vld_nxt;
      frm_err  <= ferr_nxt;
`ifdef UART_RX_PARITY_EN
      par_bad  <= par_bad_nxt;
      par_err  <= perr_nxt;
`endif
    end
  end

`ifndef UART_RX_PARITY_EN
  assign par_err = 1'b0;
`endif

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_inst_rx.sv
// Directed bench for uart_inst_rx: frames, back-to-back, glitch, framing error,
// parity (when UART_RX_PARITY_EN is defined) and mid-frame reset.
module tb_uart_inst_rx;

  localparam int unsigned CPB = 100;
`ifdef UART_RX_PARITY_EN
  localparam bit          PAR_EN = 1'b1;
  localparam int unsigned FRAME  = 11 * CPB;
`else
  localparam bit          PAR_EN = 1'b0;
  localparam int unsigned FRAME  = 10 * CPB;
`endif
  localparam int unsigned LAT = FRAME - CPB / 2 + 2;  // stop sample edge from cycle 0

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] inst_wd;
  logic       inst_vld, frm_err, par_err, busy;

  int errors = 0;
  int checks = 0;

  int unsigned cyc = 0;
  int unsigned t0;
  logic [7:0]  vld_q[$];
  int unsigned vldc_q[$];
  int          nfrm = 0, npar = 0, nmulti = 0, npar_total = 0;

  uart_inst_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .inst_wd  (inst_wd),
    .inst_vld (inst_vld),
    .frm_err  (frm_err),
    .par_err  (par_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (inst_vld === 1'b1) begin
      vld_q.push_back(inst_wd);
      vldc_q.push_back(cyc);
    end
    if (frm_err === 1'b1) nfrm++;
    if (par_err === 1'b1) begin npar++; npar_total++; end
    if ((inst_vld === 1'b1) + (frm_err === 1'b1) + (par_err === 1'b1) > 1) nmulti++;
  end

  task automatic clear_log();
    vld_q.delete();
    vldc_q.delete();
    nfrm = 0;
    npar = 0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop, input logic par);
    t0 = cyc;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    if (PAR_EN) begin
      rx = par;
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (inst_wd !== 8'h00) begin errors++; $display("FAIL reset_wd got=%h exp=00", inst_wd); end
    checks++; if (inst_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", inst_vld); end
    checks++; if (frm_err !== 1'b0) begin errors++; $display("FAIL reset_frm got=%b exp=0", frm_err); end
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL reset_par got=%b exp=0", par_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single();
    int unsigned lat;
    clear_log();
    fork
      send_byte(8'h04, 1'b1, 1'b0);
      begin
        repeat (10) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_mid got=%b exp=1", busy); end
      end
    join
    repeat (5) @(negedge clk);
    checks++; if (vld_q.size() != 1) begin errors++; $display("FAIL single_count got=%0d exp=1", vld_q.size()); end
    else begin
      lat = vldc_q[0] - (t0 + 1);
      checks++; if (vld_q[0] !== 8'h04) begin errors++; $display("FAIL single_data got=%h exp=04", vld_q[0]); end
      checks++; if (lat < LAT - 1 || lat > LAT + 1) begin errors++; $display("FAIL single_latency got=%0d exp=%0d+-1", lat, LAT); end
    end
    checks++; if (inst_wd !== 8'h04) begin errors++; $display("FAIL single_wd got=%h exp=04", inst_wd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after got=%b exp=0", busy); end
    checks++; if (nfrm + npar != 0) begin errors++; $display("FAIL single_errs got=%0d exp=0", nfrm + npar); end
  endtask

  task automatic test_back_to_back();
    clear_log();
    send_byte(8'h91, 1'b1, 1'b1);
    send_byte(8'h6E, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    checks++; if (vld_q.size() != 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", vld_q.size()); end
    else begin
      checks++; if (vld_q[0] !== 8'h91) begin errors++; $display("FAIL b2b_data0 got=%h exp=91", vld_q[0]); end
      checks++; if (vld_q[1] !== 8'h6E) begin errors++; $display("FAIL b2b_data1 got=%h exp=6e", vld_q[1]); end
      checks++; if (vldc_q[1] - vldc_q[0] != FRAME) begin errors++; $display("FAIL b2b_spacing got=%0d exp=%0d", vldc_q[1] - vldc_q[0], FRAME); end
    end
    checks++; if (nfrm + npar != 0) begin errors++; $display("FAIL b2b_errs got=%0d exp=0", nfrm + npar); end
  endtask

  task automatic test_glitch();
    clear_log();
    rx = 1'b0;
    repeat (30) @(negedge clk);
    rx = 1'b1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_high got=%b exp=1", busy); end
    repeat (30) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_low got=%b exp=0", busy); end
    repeat (CPB) @(negedge clk);
    checks++; if (vld_q.size() + nfrm + npar != 0) begin errors++; $display("FAIL glitch_strobes got=%0d exp=0", vld_q.size() + nfrm + npar); end
    checks++; if (inst_wd !== 8'h6E) begin errors++; $display("FAIL glitch_wd got=%h exp=6e", inst_wd); end
  endtask

  task automatic test_frame_err();
    clear_log();
    send_byte(8'hA5, 1'b0, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    checks++; if (nfrm != 1) begin errors++; $display("FAIL ferr_count got=%0d exp=1", nfrm); end
    checks++; if (vld_q.size() != 0) begin errors++; $display("FAIL ferr_novld got=%0d exp=0", vld_q.size()); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_wait_hi got=%b exp=1", busy); end
    checks++; if (inst_wd !== 8'h6E) begin errors++; $display("FAIL ferr_wd got=%h exp=6e", inst_wd); end
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_idle got=%b exp=0", busy); end
    send_byte(8'h3C, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    checks++; if (vld_q.size() != 1 || vld_q[0] !== 8'h3C) begin errors++; $display("FAIL ferr_next got=%0d/%h exp=1/3c", vld_q.size(), inst_wd); end
    checks++; if (nfrm != 1) begin errors++; $display("FAIL ferr_total got=%0d exp=1", nfrm); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    clear_log();
    send_byte(8'h07, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    checks++; if (npar != 1) begin errors++; $display("FAIL par_bad_count got=%0d exp=1", npar); end
    checks++; if (vld_q.size() != 0) begin errors++; $display("FAIL par_bad_novld got=%0d exp=0", vld_q.size()); end
    checks++; if (inst_wd !== 8'h3C) begin errors++; $display("FAIL par_bad_wd got=%h exp=3c", inst_wd); end
    clear_log();
    send_byte(8'h07, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    checks++; if (vld_q.size() != 1 || npar != 0) begin errors++; $display("FAIL par_good got=%0d/%0d exp=1/0", vld_q.size(), npar); end
    checks++; if (inst_wd !== 8'h07) begin errors++; $display("FAIL par_good_wd got=%h exp=07", inst_wd); end
  endtask
`endif

  task automatic test_reset_midframe();
    clear_log();
    fork
      send_byte(8'hFF, 1'b1, 1'b0);
      begin
        repeat (5 * CPB + CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (inst_wd !== 8'h00) begin errors++; $display("FAIL rstmid_wd got=%h exp=00", inst_wd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if ({inst_vld, frm_err, par_err} !== 3'b000) begin errors++; $display("FAIL rstmid_strobes got=%b exp=000", {inst_vld, frm_err, par_err}); end
        rst_n = 1'b1;
      end
    join
    repeat (2 * CPB) @(negedge clk);
    checks++; if (vld_q.size() != 0) begin errors++; $display("FAIL rstmid_novld got=%0d exp=0", vld_q.size()); end
    send_byte(8'h55, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    checks++; if (vld_q.size() != 1 || inst_wd !== 8'h55) begin errors++; $display("FAIL rstmid_next got=%0d/%h exp=1/55", vld_q.size(), inst_wd); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_midframe();
    checks++; if (nmulti != 0) begin errors++; $display("FAIL strobe_exclusive got=%0d exp=0", nmulti); end
    if (!PAR_EN) begin
      checks++; if (npar_total != 0) begin errors++; $display("FAIL par_tied got=%0d exp=0", npar_total); end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
